// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the IF->ID fetch queue: default widths/depth
// and the {PC, instr} entry record.
package fetch_queue_pkg;

  localparam int FQ_ADDR_W  = 32;
  localparam int FQ_INSTR_W = 32;
  localparam int FQ_DEPTH   = 4;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0]  pc;
    logic [FQ_INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH-entry storage for the fetch queue: synchronous write, asynchronous read.
// Contents are not reset; the control logic masks them whenever the queue is empty.
module fetch_queue_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through queue between IF and ID carrying {PC, instr} pairs.
// Holds pointer, count and flow-control logic; storage lives in fetch_queue_mem.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W  = FQ_ADDR_W,
  parameter int INSTR_W = FQ_INSTR_W,
  parameter int DEPTH   = FQ_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   start_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [ADDR_W-1:0]      PC_i,
  input  logic [INSTR_W-1:0]     instr_i,
  output logic                   ready_o,
  input  logic                   stall_i,
  output logic                   valid_o,
  output logic [ADDR_W-1:0]      PC_o,
  output logic [INSTR_W-1:0]     instr_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pushEn, popEn;
  logic [ENTRY_W-1:0] headEntry;

  // ready/valid derive from the registered count only, so a push never
  // reaches the outputs in the cycle it is accepted.
  assign ready_o = (count_q != FULL_CNT);
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  assign pushEn = push_i & ready_o & ~flush_i;
  assign popEn  = valid_o & ~stall_i & ~flush_i;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      unique case ({pushEn, popEn})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  fetch_queue_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (pushEn),
    .waddr_i (wrPtr_q),
    .wdata_i ({PC_i, instr_i}),
    .raddr_i (rdPtr_q),
    .rdata_o (headEntry)
  );

  // Empty queue presents a zero bubble rather than stale storage.
  assign PC_o    = valid_o ? headEntry[ENTRY_W-1:INSTR_W] : '0;
  assign instr_o = valid_o ? headEntry[INSTR_W-1:0]       : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a DEPTH=4 instance and a DEPTH=2/INSTR_W=16
// instance sharing clock and reset, checked against hand-computed vectors.
module tb_fetch_queue;

  typedef struct {
    logic        push;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [2:0]  expCount;
    logic        expReady;
  } vec_t;

  logic        clk = 1'b0;
  logic        startN = 1'b0;

  logic        flush1 = 1'b0, push1 = 1'b0, stall1 = 1'b0;
  logic [31:0] pcIn1 = '0, instrIn1 = '0;
  logic        ready1, valid1;
  logic [31:0] pcOut1, instrOut1;
  logic [2:0]  count1;

  logic        flush2 = 1'b0, push2 = 1'b0, stall2 = 1'b0;
  logic [31:0] pcIn2 = '0;
  logic [15:0] instrIn2 = '0;
  logic        ready2, valid2;
  logic [31:0] pcOut2;
  logic [15:0] instrOut2;
  logic [1:0]  count2;

  int checks = 0;
  int failures = 0;

  vec_t vecs1 [10];
  vec_t vecs2 [7];

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) dut1 (
    .clk_i   (clk),
    .start_i (startN),
    .flush_i (flush1),
    .push_i  (push1),
    .PC_i    (pcIn1),
    .instr_i (instrIn1),
    .ready_o (ready1),
    .stall_i (stall1),
    .valid_o (valid1),
    .PC_o    (pcOut1),
    .instr_o (instrOut1),
    .count_o (count1)
  );

  fetch_queue #(.ADDR_W(32), .INSTR_W(16), .DEPTH(2)) dut2 (
    .clk_i   (clk),
    .start_i (startN),
    .flush_i (flush2),
    .push_i  (push2),
    .PC_i    (pcIn2),
    .instr_i (instrIn2),
    .ready_o (ready2),
    .stall_i (stall2),
    .valid_o (valid2),
    .PC_o    (pcOut2),
    .instr_o (instrOut2),
    .count_o (count2)
  );

  function automatic vec_t mk(logic push, logic stall, logic flush,
                              logic [31:0] pc, logic [31:0] instr,
                              logic eV, logic [31:0] eP, logic [31:0] eI,
                              logic [2:0] eC, logic eR);
    vec_t v;
    v.push = push; v.stall = stall; v.flush = flush;
    v.pc = pc; v.instr = instr;
    v.expValid = eV; v.expPc = eP; v.expInstr = eI;
    v.expCount = eC; v.expReady = eR;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int sel, input string tag, input logic eV,
                             input logic [31:0] eP, input logic [31:0] eI,
                             input logic [2:0] eC, input logic eR);
    if (sel == 1) begin
      chk({tag, ".valid"}, 32'(valid1), 32'(eV));
      chk({tag, ".pc"},    pcOut1, eP);
      chk({tag, ".instr"}, instrOut1, eI);
      chk({tag, ".count"}, 32'(count1), 32'(eC));
      chk({tag, ".ready"}, 32'(ready1), 32'(eR));
    end else begin
      chk({tag, ".valid"}, 32'(valid2), 32'(eV));
      chk({tag, ".pc"},    pcOut2, eP);
      chk({tag, ".instr"}, 32'(instrOut2), eI);
      chk({tag, ".count"}, 32'(count2), 32'(eC));
      chk({tag, ".ready"}, 32'(ready2), 32'(eR));
    end
  endtask

  task automatic applyStimulus(input int sel, input vec_t v, input string tag);
    if (sel == 1) begin
      push1 = v.push; stall1 = v.stall; flush1 = v.flush;
      pcIn1 = v.pc;   instrIn1 = v.instr;
    end else begin
      push2 = v.push; stall2 = v.stall; flush2 = v.flush;
      pcIn2 = v.pc;   instrIn2 = v.instr[15:0];
    end
    tick();
    checkOutput(sel, tag, v.expValid, v.expPc, v.expInstr, v.expCount, v.expReady);
  endtask

  initial begin
    // Fill under stall, ignored push when full, then drain in order.
    vecs1[0] = mk(1, 1, 0, 32'h00, 32'hA000_0000, 1, 32'h00, 32'hA000_0000, 3'd1, 1);
    vecs1[1] = mk(1, 1, 0, 32'h04, 32'hA000_0004, 1, 32'h00, 32'hA000_0000, 3'd2, 1);
    vecs1[2] = mk(1, 1, 0, 32'h08, 32'hA000_0008, 1, 32'h00, 32'hA000_0000, 3'd3, 1);
    vecs1[3] = mk(1, 1, 0, 32'h0C, 32'hA000_000C, 1, 32'h00, 32'hA000_0000, 3'd4, 0);
    vecs1[4] = mk(1, 1, 0, 32'h10, 32'hA000_0010, 1, 32'h00, 32'hA000_0000, 3'd4, 0);
    vecs1[5] = mk(0, 0, 0, 32'h00, 32'h0,         1, 32'h04, 32'hA000_0004, 3'd3, 1);
    vecs1[6] = mk(0, 0, 0, 32'h00, 32'h0,         1, 32'h08, 32'hA000_0008, 3'd2, 1);
    vecs1[7] = mk(0, 0, 0, 32'h00, 32'h0,         1, 32'h0C, 32'hA000_000C, 3'd1, 1);
    vecs1[8] = mk(0, 0, 0, 32'h00, 32'h0,         0, 32'h00, 32'h0,         3'd0, 1);
    vecs1[9] = mk(1, 0, 0, 32'h20, 32'hA000_0020, 1, 32'h20, 32'hA000_0020, 3'd1, 1);

    vecs2[0] = mk(1, 1, 0, 32'h100, 32'h1100, 1, 32'h100, 32'h1100, 3'd1, 1);
    vecs2[1] = mk(1, 1, 0, 32'h104, 32'h1104, 1, 32'h100, 32'h1100, 3'd2, 0);
    vecs2[2] = mk(1, 1, 0, 32'h108, 32'h1108, 1, 32'h100, 32'h1100, 3'd2, 0);
    vecs2[3] = mk(0, 0, 0, 32'h000, 32'h0,    1, 32'h104, 32'h1104, 3'd1, 1);
    vecs2[4] = mk(1, 0, 0, 32'h10C, 32'h110C, 1, 32'h10C, 32'h110C, 3'd1, 1);
    vecs2[5] = mk(1, 0, 0, 32'h110, 32'h1110, 1, 32'h110, 32'h1110, 3'd1, 1);
    vecs2[6] = mk(0, 0, 0, 32'h000, 32'h0,    0, 32'h000, 32'h0,    3'd0, 1);

    #2;
    checkOutput(1, "reset", 0, 32'h0, 32'h0, 3'd0, 1);
    checkOutput(2, "reset2", 0, 32'h0, 32'h0, 3'd0, 1);
    tick();
    startN = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, vecs1[i], $sformatf("v1_%0d", i));
    end

    // Streaming push+pop keeps one entry and wraps both pointers.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] p;
      p = 32'h24 + 32'(4 * i);
      push1 = 1'b1; stall1 = 1'b0; pcIn1 = p; instrIn1 = 32'hA000_0000 + p;
      tick();
      checkOutput(1, $sformatf("stream_%0d", i), 1, p, 32'hA000_0000 + p, 3'd1, 1);
    end

    stall1 = 1'b1;
    pcIn1 = 32'h50; instrIn1 = 32'hA000_0050;
    tick();
    pcIn1 = 32'h54; instrIn1 = 32'hA000_0054;
    tick();
    checkOutput(1, "preflush", 1, 32'h48, 32'hA000_0048, 3'd3, 1);
    flush1 = 1'b1; pcIn1 = 32'h40; instrIn1 = 32'hA000_0040;
    tick();
    checkOutput(1, "flush", 0, 32'h0, 32'h0, 3'd0, 1);
    flush1 = 1'b0; push1 = 1'b0;
    tick();
    checkOutput(1, "postflush", 0, 32'h0, 32'h0, 3'd0, 1);
    push1 = 1'b1; pcIn1 = 32'h60; instrIn1 = 32'hA000_0060;
    tick();
    checkOutput(1, "refill", 1, 32'h60, 32'hA000_0060, 3'd1, 1);
    pcIn1 = 32'h70; instrIn1 = 32'hA000_0070;
    tick();
    checkOutput(1, "two", 1, 32'h60, 32'hA000_0060, 3'd2, 1);
    push1 = 1'b0;

    // Asynchronous reset pulse in the middle of a cycle.
    #2;
    startN = 1'b0;
    #1;
    checkOutput(1, "asyncrst", 0, 32'h0, 32'h0, 3'd0, 1);
    tick();
    startN = 1'b1;
    push1 = 1'b1; stall1 = 1'b1; pcIn1 = 32'h80; instrIn1 = 32'hA000_0080;
    #1;
    chk("nobypass.valid", 32'(valid1), 32'd0);
    tick();
    checkOutput(1, "afterrst", 1, 32'h80, 32'hA000_0080, 3'd1, 1);
    push1 = 1'b0; stall1 = 1'b0;
    tick();
    checkOutput(1, "drained", 0, 32'h0, 32'h0, 3'd0, 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(2, vecs2[i], $sformatf("v2_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32, width of the carried PC.
REQ-002 Parameter INSTR_W, default 32, width of the carried instruction.
REQ-003 Parameter DEPTH, default 4, entry count; legal values are powers of two, minimum 2.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 start_i  input  1  reset; asynchronous, active-low.
REQ-006 flush_i  input  1  synchronous discard of all entries.
REQ-007 push_i  input  1  IF presents a valid PC/instr pair.
REQ-008 PC_i  input  ADDR_W  PC of the pushed entry.
REQ-009 instr_i  input  INSTR_W  instruction of the pushed entry.
REQ-010 ready_o  output  1  queue can accept a push this cycle.
REQ-011 stall_i  input  1  ID holds its current entry; no pop occurs.
REQ-012 valid_o  output  1  head entry present on PC_o/instr_o.
REQ-013 PC_o  output  ADDR_W  head-entry PC.
REQ-014 instr_o  output  INSTR_W  head-entry instruction.
REQ-015 count_o  output  clog2(DEPTH)+1  number of stored entries.

Function
REQ-016 Push is accepted when push_i=1, ready_o=1 and flush_i=0.
REQ-017 ready_o shall equal (count_o != DEPTH) and shall be a function of registered state only.
REQ-018 A pop occurs when valid_o=1, stall_i=0 and flush_i=0.
REQ-019 The queue is first-word-fall-through: valid_o=(count_o!=0), and PC_o/instr_o show the oldest entry with no extra cycle.
REQ-020 When valid_o=0, PC_o and instr_o shall be all-zero (bubble).
REQ-021 A pushed entry is visible at the head no earlier than the cycle after acceptance; no combinational push-to-output bypass.
REQ-022 A simultaneous push and pop leaves count_o unchanged and advances both pointers.
REQ-023 A push while full does not occur because ready_o=0; a push_i in that cycle is ignored, with no storage change.
REQ-024 Read and write pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-025 flush_i=1 has priority over push and pop: next cycle count_o=0, pointers=0 and valid_o=0, and the same-cycle push is dropped.
REQ-026 With stall_i=1 and flush_i=0, the head entry and its outputs are held unchanged while pushes continue until the queue is full.

Reset
REQ-027 start_i=0 shall immediately force count_o=0, both pointers=0, valid_o=0, PC_o=0, instr_o=0 and ready_o=1, independent of clk_i.
REQ-028 Storage array contents need no reset; they are never observable while valid_o=0.
REQ-029 Reset deassertion mid-stream shall leave the queue empty; the first accepted push after release appears at the head one cycle later.

Structure
REQ-030 The ADDR_W/INSTR_W/DEPTH defaults and the entry record type {PC, instr} shall be held in the shared pipeline package.
REQ-031 One sub-module, fetch_queue_mem, shall implement the DEPTH-entry storage: synchronous write and asynchronous read.
REQ-032 Pointer, count and control logic shall be held in fetch_queue itself.

Verification
REQ-033 Reset then 4 pushes (PC 0x00,0x04,0x08,0x0C) with stall_i=1 -> count_o=4 and ready_o=0; a 5th push (0x10) is ignored.
REQ-034 From full, release stall_i for 4 cycles -> PC_o sequence 0x00,0x04,0x08,0x0C, then valid_o=0 and PC_o=instr_o=0.
REQ-035 Continuous push and pop for 10 cycles with DEPTH=4 -> pointer wrap occurs, count_o holds at 1, and output order matches input order.
REQ-036 Queue holds 3 entries; flush_i=1 together with push_i=1 (PC 0x40) -> next cycle count_o=0 and valid_o=0, and 0x40 never appears.
REQ-037 Queue holds 2 entries and start_i is pulsed low mid-cycle -> outputs are zero before the next clk_i edge, and count_o=0.
REQ-038 Parameters DEPTH=2, INSTR_W=16 -> fill, drain and wrap scenarios pass, and count_o is 2 bits wide.
